sram_req_adapter: RTL and testbench

- Initiator-side front end for the single-port SRAM wrapper (`cc_ram_1p_adv`-style port): fixed read latency, one response per request, no backpressure.
- Converts a valid/ready request channel into SRAM port requests.
- Collects every SRAM response (reads and write acks) into a response FIFO exposed as a valid/ready channel.
- Credit-based admission guarantees the FIFO never overflows even though the SRAM cannot be stalled.

---
 rtl/sram_req_adapter_if.sv | 28 ++
 rtl/sram_req_adapter.sv | 137 +++++++++++++
 tb/tb_sram_req_adapter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_adapter_if.sv
// Initiator-side request/response channel of sram_req_adapter.
// The adapter is the slave; whoever issues requests and takes responses is the master.
interface sram_req_adapter_if #(
    parameter int unsigned AddrWidth = 9,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = 4
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [BeWidth-1:0]   req_be_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic [1:0]           rsp_rerror_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rerror_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rerror_o
    );
endinterface

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a fixed-latency single-port SRAM. Credits bound the number of
// unpopped requests so the response FIFO can always absorb what the unstallable SRAM returns.
module sram_req_adapter #(
    parameter int unsigned NumWords  = 512,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 4,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    sram_req_adapter_if.slave    bus,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    input  logic                 sram_rvalid_i,
    input  logic [1:0]           sram_rerror_i,
    output logic                 err_o
);
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RspDepth - 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [1:0]           rerror;
    } rsp_entry_t;

    logic [CntWidth-1:0] credit_q, credit_d;
    logic [CntWidth-1:0] inflight_q, inflight_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic                err_q, err_d;
    rsp_entry_t          mem_q [RspDepth];
    rsp_entry_t          head;

    logic accept, pop, stray, rsp_ret, fifo_full, push, overflow;

    // Ready depends on registered credits only, so no path exists from rsp_ready_i or req_valid_i.
    assign bus.req_ready_o = (credit_q < DepthCnt);
    assign accept          = bus.req_valid_i & bus.req_ready_o;

    assign sram_req_o   = accept;
    assign sram_we_o    = bus.req_we_i;
    assign sram_addr_o  = bus.req_addr_i;
    assign sram_wdata_o = bus.req_wdata_i;
    assign sram_be_o    = bus.req_be_i;

    assign bus.rsp_valid_o = (count_q != '0);
    assign pop             = bus.rsp_valid_o & bus.rsp_ready_i;

    // A response nobody asked for is flagged and dropped without touching any counter.
    assign stray     = sram_rvalid_i & (inflight_q == '0) & ~accept;
    assign rsp_ret   = sram_rvalid_i & ~stray;
    assign fifo_full = (count_q == DepthCnt);
    assign push      = rsp_ret & (~fifo_full | pop);
    assign overflow  = rsp_ret & fifo_full & ~pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every target gets a default first so no path through this block infers a latch.
        credit_d   = credit_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        err_d      = err_q | stray | overflow;

        case ({accept, pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: ;
        endcase

        case ({accept, rsp_ret})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: ;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase

        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    // NOTE: storage is not reset; the output mux below hides stale entries while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= rsp_entry_t'({sram_rdata_i, sram_rerror_i});
    end

    always_comb begin
        head = '0;
        if (bus.rsp_valid_o) head = mem_q[rptr_q];
    end

    assign bus.rsp_rdata_o  = head.rdata;
    assign bus.rsp_rerror_o = head.rerror;
    assign err_o            = err_q;

    param_legal_a: assert property (@(posedge clk_i)
        (Latency >= 1) && (Latency <= 3) && (RspDepth >= Latency + 1));
    credit_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (credit_q <= DepthCnt) && (inflight_q <= credit_q));
endmodule

// File: tb/tb_sram_req_adapter.sv
// Drives a Latency=1 and a Latency=3 adapter in lockstep, each with its own SRAM model, and
// checks both against an ordered expected-response list built from accepted requests.
`timescale 1ns/1ps
module tb_sram_req_adapter;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic inj   = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat [2] = '{1, 3};

    sram_req_adapter_if #(.AddrWidth(9), .DataWidth(32), .BeWidth(4)) if1 ();
    sram_req_adapter_if #(.AddrWidth(9), .DataWidth(32), .BeWidth(4)) if3 ();

    logic        s1_req, s1_we, s1_rvalid, err1;
    logic [8:0]  s1_addr;
    logic [31:0] s1_wdata, s1_rdata;
    logic [3:0]  s1_be;
    logic [1:0]  s1_rerr;
    logic        s3_req, s3_we, s3_rvalid, err3;
    logic [8:0]  s3_addr;
    logic [31:0] s3_wdata, s3_rdata;
    logic [3:0]  s3_be;
    logic [1:0]  s3_rerr;

    sram_req_adapter #(.Latency(1), .RspDepth(DEPTH)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1),
        .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr),
        .sram_wdata_o(s1_wdata), .sram_be_o(s1_be), .sram_rdata_i(s1_rdata),
        .sram_rvalid_i(s1_rvalid), .sram_rerror_i(s1_rerr), .err_o(err1));

    sram_req_adapter #(.Latency(3), .RspDepth(DEPTH)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if3),
        .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_addr_o(s3_addr),
        .sram_wdata_o(s3_wdata), .sram_be_o(s3_be), .sram_rdata_i(s3_rdata),
        .sram_rvalid_i(s3_rvalid), .sram_rerror_i(s3_rerr), .err_o(err3));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // SRAM error rule: the upper half of the array reports addr[1:0], the lower half is clean.
    function automatic logic [1:0] err_rule(input logic [8:0] a);
        return a[8] ? a[1:0] : 2'b00;
    endfunction

    // SRAM models: memories updated by the stimulus process, fixed-latency return pipelines.
    logic [31:0] smem1 [512];
    logic [31:0] smem3 [512];
    logic [31:0] rd1_now, rd3_now;
    logic [2:0]  pv1, pv3;
    logic [2:0][33:0] pd1, pd3;
    assign rd1_now = smem1[s1_addr];
    assign rd3_now = smem3[s3_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv1 <= '0; pd1 <= '0; pv3 <= '0; pd3 <= '0;
        end else begin
            pv1 <= {pv1[1:0], s1_req};
            pd1 <= {pd1[1:0], (s1_we ? 32'h0 : rd1_now), err_rule(s1_addr)};
            pv3 <= {pv3[1:0], s3_req};
            pd3 <= {pd3[1:0], (s3_we ? 32'h0 : rd3_now), err_rule(s3_addr)};
        end
    end
    assign s1_rvalid = pv1[0] | inj;
    assign s1_rdata  = pd1[0][33:2];
    assign s1_rerr   = pd1[0][1:0];
    assign s3_rvalid = pv3[2];
    assign s3_rdata  = pd3[2][33:2];
    assign s3_rerr   = pd3[2][1:0];

    // Reference: expected memory contents and the ordered list of owed responses per instance.
    logic [31:0] rmem  [2][512];
    logic [31:0] q_data[2][64];
    logic [1:0]  q_err [2][64];
    logic        q_rd  [2][64];
    int          q_cyc [2][64];
    int          head_i[2] = '{0, 0};
    int          tail_i[2] = '{0, 0};
    int          acc_cnt[2] = '{0, 0};
    logic        ref_err[2] = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic v, input logic we, input logic [8:0] a,
                              input logic [31:0] d, input logic [3:0] be, input logic rr,
                              input logic o_ready, input logic o_valid, input logic [31:0] o_rdata,
                              input logic [1:0] o_rerr, input logic o_err, input logic [63:0] o_credit,
                              input logic o_sreq, input logic [8:0] o_saddr);
        string p;
        int    outst, h, t;
        logic  vis;
        p     = (k == 0) ? "L1" : "L3";
        outst = tail_i[k] - head_i[k];
        h     = head_i[k] % 64;
        vis   = (outst > 0) && (cyc >= q_cyc[k][h] + lat[k] + 1);
        chk({p, "_req_ready"}, o_ready, outst < DEPTH);
        chk({p, "_credit"}, o_credit, outst);
        chk({p, "_rsp_valid"}, o_valid, vis);
        chk({p, "_err"}, o_err, ref_err[k]);
        chk({p, "_sram_req"}, o_sreq, v && (outst < DEPTH));
        if (v) chk({p, "_sram_addr"}, o_saddr, a);
        if (vis && o_valid && rr) begin
            chk({p, "_rsp_rerror"}, o_rerr, q_err[k][h]);
            if (q_rd[k][h]) chk({p, "_rsp_rdata"}, o_rdata, q_data[k][h]);
            head_i[k]++;
        end
        if (v && o_ready) begin
            t            = tail_i[k] % 64;
            q_rd[k][t]   = !we;
            q_data[k][t] = rmem[k][a];
            q_err[k][t]  = err_rule(a);
            q_cyc[k][t]  = cyc;
            if (we) rmem[k][a] = merge(rmem[k][a], d, be);
            tail_i[k]++;
            acc_cnt[k]++;
        end
    endtask

    task automatic step(input logic v, input logic we, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic rr, input logic ij);
        @(negedge clk);
        if1.req_valid_i = v; if1.req_we_i = we; if1.req_addr_i = a;
        if1.req_wdata_i = d; if1.req_be_i = be; if1.rsp_ready_i = rr;
        if3.req_valid_i = v; if3.req_we_i = we; if3.req_addr_i = a;
        if3.req_wdata_i = d; if3.req_be_i = be; if3.rsp_ready_i = rr;
        inj = ij;
        #1;
        check_inst(0, v, we, a, d, be, rr, if1.req_ready_o, if1.rsp_valid_o, if1.rsp_rdata_o,
                   if1.rsp_rerror_o, err1, 64'(dut1.credit_q), s1_req, s1_addr);
        check_inst(1, v, we, a, d, be, rr, if3.req_ready_o, if3.rsp_valid_o, if3.rsp_rdata_o,
                   if3.rsp_rerror_o, err3, 64'(dut3.credit_q), s3_req, s3_addr);
        if (s1_req && s1_we) smem1[s1_addr] = merge(smem1[s1_addr], s1_wdata, s1_be);
        if (s3_req && s3_we) smem3[s3_addr] = merge(smem3[s3_addr], s3_wdata, s3_be);
        if (ij && !v && (tail_i[0] == head_i[0])) ref_err[0] = 1'b1;
        cyc++;
    endtask

    task automatic chk_reset_values();
        chk("L1_rst_ready", if1.req_ready_o, 1'b1);
        chk("L1_rst_valid", if1.rsp_valid_o, 1'b0);
        chk("L1_rst_rdata", if1.rsp_rdata_o, 32'h0);
        chk("L1_rst_rerror", if1.rsp_rerror_o, 2'b00);
        chk("L1_rst_sram_req", s1_req, 1'b0);
        chk("L1_rst_err", err1, 1'b0);
        chk("L3_rst_ready", if3.req_ready_o, 1'b1);
        chk("L3_rst_valid", if3.rsp_valid_o, 1'b0);
        chk("L3_rst_sram_req", s3_req, 1'b0);
        chk("L3_rst_err", err3, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && (head_i[0] != tail_i[0] || head_i[1] != tail_i[1]); i++)
            step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        chk({tag, "_L1_drained"}, tail_i[0] - head_i[0], 0);
        chk({tag, "_L3_drained"}, tail_i[1] - head_i[1], 0);
    endtask

    initial begin
        int a0, a1;
        logic [31:0] init_v;
        for (int i = 0; i < 512; i++) begin
            init_v      = 32'hA5A5_0000 ^ (i * 32'h0001_0003);
            smem1[i]    = init_v;
            smem3[i]    = init_v;
            rmem[0][i]  = init_v;
            rmem[1][i]  = init_v;
        end
        smem1[16] = 32'hDEADBEEF; smem3[16] = 32'hDEADBEEF;
        rmem[0][16] = 32'hDEADBEEF; rmem[1][16] = 32'hDEADBEEF;

        if1.req_valid_i = 0; if1.req_we_i = 0; if1.req_addr_i = 0;
        if1.req_wdata_i = 0; if1.req_be_i = 0; if1.rsp_ready_i = 0;
        if3.req_valid_i = 0; if3.req_we_i = 0; if3.req_addr_i = 0;
        if3.req_wdata_i = 0; if3.req_be_i = 0; if3.rsp_ready_i = 0;

        #2 rst_n = 1'b0;
        #1 chk_reset_values();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Single read of 0x10.
        step(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Write then read back-to-back at 0x5.
        step(1'b1, 1'b1, 9'h005, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 9'h005, 32'h0, 4'h0, 1'b1, 1'b0);
        drain("wr_rd");

        // Stall responses: exactly DEPTH accepts, then drain in order.
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 9'(i + 8), 32'h0, 4'h0, 1'b0, 1'b0);
        chk("L1_stall_accepts", acc_cnt[0] - a0, DEPTH);
        chk("L3_stall_accepts", acc_cnt[1] - a1, DEPTH);
        drain("stall");

        // Continuous traffic with responses always taken.
        a0 = acc_cnt[0];
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        chk("L1_steady_accepts", acc_cnt[0] - a0, 40);
        drain("steady");

        // Unsolicited SRAM response on the Latency=1 instance.
        step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b1, 1'b0);
        drain("stray");

        // Random mix of reads, writes, upper-half error addresses and response stalls.
        for (int i = 0; i < 300; i++)
            step(($urandom % 10) < 7, ($urandom % 3) == 0,
                 (($urandom % 4) == 0) ? 9'(9'h100 + ($urandom % 16)) : 9'($urandom % 16),
                 $urandom, 4'($urandom % 16), ($urandom % 10) < 6, 1'b0);
        drain("random");

        // Asynchronous reset with two requests outstanding.
        step(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h005, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        if1.req_valid_i = 1'b0; if3.req_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_values();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            head_i[k]  = tail_i[k];
            ref_err[k] = 1'b0;
        end
        repeat (6) step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 9'h005, 32'h0, 4'h0, 1'b1, 1'b0);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
